alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that runs 16-bit unsigned multiply, divide and remainder as iterations on the shared 16-bit ALU. It sits beside the execute stage: while busy, it owns the ALU's a/b/alu_op inputs through the execute-stage mux, and it reads the ALU result back every cycle. The core stalls on busy and takes the result on done.

Parameters:
WIDTH, 16, operand/result width; only 16 is supported and verified (matches ALU width)
DIV0_QUOT, 16'hFFFF, quotient returned for divide by zero (documents the natural restoring-division result)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request pulse; accepted only in IDLE or DONE
op  in  2  00 MUL (low 16 bits of product), 01 DIVU (quotient), 10 REMU (remainder), 11 reserved
src_a  in  16  multiplicand / dividend
src_b  in  16  multiplier / divisor
flush  in  1  synchronous abort of any in-flight operation
busy  out  1  high in RUN
done  out  1  one-cycle pulse in DONE
result  out  16  registered result; held until the next accepted start
alu_a  out  16  ALU operand a (combinational from state)
alu_b  out  16  ALU operand b
alu_op  out  4  ALU operation code (`ALU_* encodings from defines.v)
alu_result  in  16  ALU result, same cycle

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, result=0, cnt=0; all internal registers 0. Reset during RUN discards the operation and produces no done.
- States:
  - IDLE: wait for start.
  - RUN: exactly 16 cycles, cnt 0..15.
  - DONE: 1 cycle, then IDLE.
  - Transitions: IDLE/DONE -(start)-> RUN; RUN -(cnt==15)-> DONE; DONE -(no start)-> IDLE.
- Latency: start sampled at edge T; RUN occupies cycles T+1..T+16; done=1 during cycle T+17; result is valid from T+17.
- Back-to-back: start in the DONE cycle is accepted and goes directly to RUN. result keeps the previous value until the new DONE.
- start while in RUN is ignored (no queueing).
- flush in RUN: state goes to IDLE at the next edge, and busy drops. There is no done, and result is unchanged. flush takes priority over start and over the cnt==15 transition. flush in IDLE or DONE has no effect on state, and a simultaneous start in those states is dropped.
- Outside RUN: alu_op=`ALU_ADD, alu_a=0, alu_b=0.
- MUL (shift-add, LSB first):
  - Registers: acc (16), mcand (16), mplier (16).
  - Each RUN cycle drives alu_a=acc, alu_b=mcand, alu_op=`ALU_ADD.
  - If mplier[0]==1, acc<=alu_result. Every cycle, mcand<=mcand<<1 and mplier<=mplier>>1.
  - Modulo 2^16; overflow is discarded.
- DIVU/REMU (restoring, MSB first):
  - Registers: rem (17), quo (16, preloaded with dividend), dvs (16).
  - Each cycle forms t = {rem[15:0], quo[15]} and drives alu_a=t[15:0], alu_b=dvs, alu_op=`ALU_SUB.
  - ge = t[16] | (t[15:0] >= dvs) is an internal unsigned compare; the ALU SLT is signed and is not used for this.
  - If ge: rem<={1'b0, alu_result}, quo<={quo[14:0],1}. Otherwise: rem<=t, quo<={quo[14:0],0}.
- Divide by zero: no special path. The algorithm yields quotient 16'hFFFF (=DIV0_QUOT) and remainder = dividend, with the same 16-cycle latency.
- Reserved op 11: same timing; result=0; the ALU is driven with `ALU_ADD and zeros.
- DONE loads result from acc (MUL), quo (DIVU) or rem[15:0] (REMU).
- op, src_a and src_b are sampled only at the accepting edge; later changes have no effect.

Decomposition:
- defines.v (shared): add MD_OP_MUL=2'b00, MD_OP_DIVU=2'b01, MD_OP_REMU=2'b10, MD_CNT_LAST=4'd15, and state encodings MD_IDLE/MD_RUN/MD_DONE. The existing `ALU_ADD/`ALU_SUB codes are reused.
- Single module; no sub-module. The ALU stays external, and its input mux (selected by busy) lives in the execute stage.

Test Plan:
- MUL 7*6: start at T -> busy T+1..T+16, done at T+17 only, result=16'd42; alu_op=`ALU_ADD throughout RUN.
- MUL 16'h1234*16'h0100 -> result 16'h3400 (truncated); then back-to-back start in the DONE cycle with DIVU 100/7 -> second done 17 cycles later, result=16'd14.
- REMU 100/7 -> 16'd2; DIVU 16'hFFFF/16'h0001 -> 16'hFFFF; REMU 5/9 -> 16'd5.
- DIVU 16'hBEEF/0 -> 16'hFFFF; REMU 16'hBEEF/0 -> 16'hBEEF; both with 17-cycle latency.
- MUL started, flush at the 5th RUN cycle -> busy=0 the next cycle, done never asserted, result keeps its prior value; start pulsed mid-RUN on another op is ignored.
- async rst asserted between clock edges mid-RUN -> busy/done/result=0 immediately; after release, the next start behaves normally.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer:
// ALU operation codes, sequencer op codes, iteration bound and FSM states.
package alu_muldiv_seq_pkg;

  // ALU operation codes shared with the execute-stage ALU.
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  // Sequencer operation select.
  localparam logic [1:0] MD_OP_MUL  = 2'b00;
  localparam logic [1:0] MD_OP_DIVU = 2'b01;
  localparam logic [1:0] MD_OP_REMU = 2'b10;

  // Last iteration index: one iteration per operand bit.
  localparam int unsigned MD_CNT_W    = 4;
  localparam logic [3:0]  MD_CNT_LAST = 4'd15;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // ALU opcode used while iterating a given sequencer op.
  function automatic logic [3:0] md_alu_op(input logic [1:0] op);
    case (op)
      MD_OP_DIVU, MD_OP_REMU: md_alu_op = ALU_SUB;
      default:                md_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 16-bit unsigned MUL / DIVU / REMU sequencer. Each operation
// takes 16 RUN cycles on the shared external ALU: shift-add multiply (LSB
// first) or restoring division (MSB first). Result is registered and held
// until the next accepted start.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] DIV0_QUOT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  // The iteration count and the all-ones divide-by-zero quotient both
  // follow from a 16-bit datapath; refuse any other configuration.
  generate
    if (WIDTH != 16 || DIV0_QUOT != {WIDTH{1'b1}}) begin : g_bad_cfg
      $error("alu_muldiv_seq supports only WIDTH=16 with DIV0_QUOT=16'hFFFF");
    end
  endgenerate

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  // Multiply registers
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  // Divide registers
  logic [WIDTH:0]        rem_q, rem_d;
  logic [WIDTH-1:0]      quo_q, quo_d;
  logic [WIDTH-1:0]      dvs_q, dvs_d;
  logic [WIDTH-1:0]      result_q, result_d;

  logic                  accept;
  logic                  finish;
  logic                  iterate;
  logic [WIDTH:0]        div_t;
  logic                  div_ge;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign div_t  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  // Unsigned trial compare done locally; the ALU's SLT is signed. rem_q's
  // top bit is always 0 between iterations, but folding it in keeps the
  // subtract decision correct should it ever be set.
  assign div_ge = rem_q[WIDTH] | div_t[WIDTH] | (div_t[WIDTH-1:0] >= dvs_q);

  // State register and iteration datapath, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
    end
  end

  // Next-state and status: flush wins over start and over the last-cycle exit.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    finish  = 1'b0;
    iterate = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          accept  = 1'b1;
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        busy = 1'b1;
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          iterate = 1'b1;
          if (cnt_q == MD_CNT_LAST) begin
            finish  = 1'b1;
            state_d = MD_DONE;
          end
        end
      end
      MD_DONE: begin
        done = 1'b1;
        if (start && !flush) begin
          accept  = 1'b1;
          state_d = MD_RUN;
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // ALU operand drive: only RUN uses the ALU, idle value is ADD 0+0.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (state_q == MD_RUN) begin
      alu_op = md_alu_op(op_q);
      case (op_q)
        MD_OP_MUL: begin
          alu_a = acc_q;
          alu_b = mcand_q;
        end
        MD_OP_DIVU, MD_OP_REMU: begin
          alu_a = div_t[WIDTH-1:0];
          alu_b = dvs_q;
        end
        default: ;
      endcase
    end
  end

  // Operand capture on accept, one shift-add / restoring step per RUN cycle,
  // and result capture on the final iteration.
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;

    if (accept) begin
      cnt_d    = '0;
      op_d     = op;
      acc_d    = '0;
      mcand_d  = src_a;
      mplier_d = src_b;
      rem_d    = '0;
      quo_d    = src_a;
      dvs_d    = src_b;
    end else if (iterate) begin
      cnt_d = cnt_q + 1'b1;
      case (op_q)
        MD_OP_MUL: begin
          if (mplier_q[0]) acc_d = alu_result;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        MD_OP_DIVU, MD_OP_REMU: begin
          if (div_ge) begin
            rem_d = {1'b0, alu_result};
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_t;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end

    if (finish) begin
      case (op_q)
        MD_OP_MUL:  result_d = acc_d;
        MD_OP_DIVU: result_d = quo_d;
        MD_OP_REMU: result_d = rem_d[WIDTH-1:0];
        default:    result_d = '0;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural ADD/SUB ALU beside it.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;

  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv_seq #(.WIDTH(16), .DIV0_QUOT(16'hFFFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU stand-in
  always_comb begin
    alu_result = 16'h0000;
    if (alu_op == ALU_ADD)      alu_result = alu_a + alu_b;
    else if (alu_op == ALU_SUB) alu_result = alu_a - alu_b;
  end

  // From a negedge: issue one op with expected result, check 16 busy cycles,
  // then stop at the negedge of the DONE cycle (so a back-to-back start may follow).
  task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res,
                        input logic [15:0] prev_res, input bit inject_start);
    logic [3:0]  exp_aop;
    logic [15:0] exp_a0, exp_b0;
    exp_aop = (o == MD_OP_DIVU || o == MD_OP_REMU) ? ALU_SUB : ALU_ADD;
    if (o == MD_OP_MUL)      begin exp_a0 = 16'h0;            exp_b0 = a; end
    else if (o == 2'b11)     begin exp_a0 = 16'h0;            exp_b0 = 16'h0; end
    else                     begin exp_a0 = {15'h0, a[15]};   exp_b0 = b; end
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = 2'b11; src_a = 16'hA5A5; src_b = 16'h5A5A;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s run%0d busy/done: got %b/%b need 1/0", name, i, busy, done);
      end
      n_checks++;
      if (alu_op !== exp_aop) begin
        n_fail++;
        $display("FAIL %s run%0d alu_op: got %h need %h", name, i, alu_op, exp_aop);
      end
      if (i == 0) begin
        n_checks++;
        if (alu_a !== exp_a0 || alu_b !== exp_b0) begin
          n_fail++;
          $display("FAIL %s first alu_a/alu_b: got %h/%h need %h/%h",
                   name, alu_a, alu_b, exp_a0, exp_b0);
        end
      end
      if (i == 0 || i == 15) begin
        n_checks++;
        if (result !== prev_res) begin
          n_fail++;
          $display("FAIL %s held result run%0d: got %h need %h", name, i, result, prev_res);
        end
      end
      if (inject_start && i == 4) begin
        start = 1'b1; op = MD_OP_DIVU; src_a = 16'd9; src_b = 16'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done cycle busy/done: got %b/%b need 0/1", name, busy, done);
    end
    n_checks++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %h need %h", name, result, exp_res);
    end
    $display("txn %s op=%0d a=%h b=%h result=%h", name, o, a, b, result);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0) begin
      n_fail++;
      $display("FAIL reset outputs: got busy=%b done=%b result=%h need 0/0/0000", busy, done, result);
    end
    n_checks++;
    if (alu_op !== ALU_ADD || alu_a !== 16'h0 || alu_b !== 16'h0) begin
      n_fail++;
      $display("FAIL reset alu drive: got op=%h a=%h b=%h need %h/0000/0000", alu_op, alu_a, alu_b, ALU_ADD);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op("mul_7x6", MD_OP_MUL, 16'd7, 16'd6, 16'd42, 16'd0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mul after done busy/done: got %b/%b need 0/0", busy, done);
    end
    n_checks++;
    if (alu_op !== ALU_ADD || alu_a !== 16'h0 || alu_b !== 16'h0) begin
      n_fail++;
      $display("FAIL idle alu drive: got op=%h a=%h b=%h need %h/0000/0000", alu_op, alu_a, alu_b, ALU_ADD);
    end
  endtask

  task automatic test_back_to_back();
    run_op("mul_trunc", MD_OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'd42, 1'b0);
    run_op("b2b_divu", MD_OP_DIVU, 16'd100, 16'd7, 16'd14, 16'h3400, 1'b0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b done pulse width: got %b need 0", done);
    end
  endtask

  task automatic test_divrem();
    run_op("remu_100_7", MD_OP_REMU, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0);
    @(negedge clk);
    run_op("divu_ffff_1", MD_OP_DIVU, 16'hFFFF, 16'h0001, 16'hFFFF, 16'd2, 1'b0);
    @(negedge clk);
    run_op("remu_5_9", MD_OP_REMU, 16'd5, 16'd9, 16'd5, 16'hFFFF, 1'b0);
    @(negedge clk);
    run_op("reserved", 2'b11, 16'd5, 16'd6, 16'd0, 16'd5, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_div0();
    run_op("divu_by0", MD_OP_DIVU, 16'hBEEF, 16'h0000, 16'hFFFF, 16'd0, 1'b0);
    @(negedge clk);
    run_op("remu_by0", MD_OP_REMU, 16'hBEEF, 16'h0000, 16'hBEEF, 16'hFFFF, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit saw_done;
    start = 1'b1; op = MD_OP_MUL; src_a = 16'd7; src_b = 16'd6;
    @(negedge clk);
    start = 1'b0;
    // RUN cycles 1..4; a foreign start in cycle 2 must be ignored
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);
      op    = MD_OP_DIVU;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush 5th run cycle busy: got %b need 1", busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush busy drop: got %b need 0", busy);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush done seen: got %b need 0", saw_done);
    end
    n_checks++;
    if (result !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL flush result kept: got %h need beef", result);
    end
    $display("txn flush_mul result=%h busy=%b", result, busy);
    // start together with flush in IDLE is dropped
    start = 1'b1; flush = 1'b1; op = MD_OP_MUL; src_a = 16'd2; src_b = 16'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle flush+start busy: got %b need 0", busy);
    end
    $display("txn idle_flush_start busy=%b", busy);
  endtask

  task automatic test_async_reset();
    start = 1'b1; op = MD_OP_MUL; src_a = 16'd3; src_b = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0) begin
      n_fail++;
      $display("FAIL async reset: got busy=%b done=%b result=%h need 0/0/0000", busy, done, result);
    end
    $display("txn async_reset busy=%b done=%b result=%h", busy, done, result);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post_rst_remu", MD_OP_REMU, 16'd100, 16'd7, 16'd2, 16'd0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_back_to_back();
    test_divrem();
    test_div0();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
